// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage data memory. It handles byte, halfword and word
// loads and stores with little-endian lanes over a req/ready/done handshake,
// with a configurable number of wait states. Accesses that are misaligned,
// out of range or use the reserved size return err and leave memory untouched.
module data_mem_ctrl #(
  parameter int DEPTH       = 200,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              ready_q;
  logic              done_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  // Memory contents are deliberately not reset.
  logic [31:0] mem_q [DEPTH];

  logic [1:0]       lane;
  logic [IDX_W-1:0] widx;
  logic             in_range;
  logic             acc_err;
  logic             access;
  logic             mem_wr;
  logic [31:0]      rd_word;
  logic [31:0]      shifted;
  logic [31:0]      load_val;
  logic [31:0]      rdata_d;
  logic             err_d;
  logic [3:0]       lane_be;
  logic [31:0]      lane_data;

  // Decode the latched request: range and alignment checks, then load formatting.
  always_comb begin
    lane     = addr_q[1:0];
    widx     = addr_q[IDX_W+1:2];
    in_range = ({2'b00, addr_q[ADDR_W-1:2]} < ADDR_W'(DEPTH));
    acc_err  = !in_range
             || (size_q == 2'b11)
             || ((size_q == 2'b01) && addr_q[0])
             || ((size_q == 2'b10) && (lane != 2'b00));
    access   = (state_q == S_BUSY) && (cnt_q == 4'd0);
    mem_wr   = access && we_q && !acc_err;
    rd_word  = in_range ? mem_q[widx] : 32'h0;
    shifted  = rd_word >> {lane, 3'b000};
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
      2'b01:   load_val = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
    err_d   = acc_err;
    rdata_d = (acc_err || we_q) ? 32'h0 : load_val;
  end

  // Per-lane write enables and store data replicated into every lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_be[gi] = (size_q == 2'b10)
                       || ((size_q == 2'b01) && (addr_q[1] == gi[1]))
                       || ((size_q == 2'b00) && (lane == gi[1:0]));
    assign lane_data[gi*8 +: 8] = (size_q == 2'b10) ? wdata_q[gi*8 +: 8]
                                : (size_q == 2'b01) ? wdata_q[(gi%2)*8 +: 8]
                                :                     wdata_q[7:0];
  end

  // Store commits on the final BUSY edge; only the enabled lanes change.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) mem_q[widx][i*8 +: 8] <= lane_data[i*8 +: 8];
      end
    end
  end

  // Handshake FSM with registered ready/done/rdata/err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            uns_q   <= uns;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= 4'(WAIT_STATES);
            ready_q <= 1'b0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q == 4'd0) begin
            done_q  <= 1'b1;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          done_q  <= 1'b0;
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with no wait states and one
// with three wait states, checked against hand-computed values.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req0, we0, uns0;
  logic [1:0]  size0;
  logic [31:0] addr0, wdata0;
  logic        ready0, done0, err0;
  logic [31:0] rdata0;
  logic        req3, we3, uns3;
  logic [1:0]  size3;
  logic [31:0] addr3, wdata3;
  logic        ready3, done3, err3;
  logic [31:0] rdata3;

  int passed = 0;
  int total  = 0;

  data_mem_ctrl #(.DEPTH(200), .ADDR_W(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .size(size0), .uns(uns0),
    .addr(addr0), .wdata(wdata0), .ready(ready0), .done(done0), .rdata(rdata0), .err(err0)
  );

  data_mem_ctrl #(.DEPTH(200), .ADDR_W(32), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .size(size3), .uns(uns3),
    .addr(addr3), .wdata(wdata3), .ready(ready3), .done(done3), .rdata(rdata3), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One access on the zero-wait instance; latency must be two cycles.
  task automatic acc0(input string tag, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e);
    int lat;
    @(negedge clk);
    req0 = 1'b1; we0 = w; size0 = sz; uns0 = u; addr0 = a; wdata0 = wd;
    @(negedge clk);
    req0 = 1'b0;
    lat = 1;
    while (!done0 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rd = rdata0;
    e  = err0;
    check({tag, "_lat"}, 32'(lat), 32'd2);
    $display("acc0 %s we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             tag, w, sz, u, a, wd, rd, e, lat);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          n, dcnt, t, t1, t2;

    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; size0 = 2'b11; uns0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    req3 = 1'b0; we3 = 1'b0; size3 = 2'b10; uns3 = 1'b0; addr3 = 32'h0; wdata3 = 32'h0;

    // Reset held with req asserted: no access starts.
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", {31'h0, ready0}, 32'h1);
      check("rst_done", {31'h0, done0}, 32'h0);
    end
    check("rst_rdata", rdata0, 32'h0);
    check("rst_err", {31'h0, err0}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_accept", {31'h0, ready0}, 32'h0);
    @(negedge clk);
    check("post_rst_done", {31'h0, done0}, 32'h1);
    check("post_rst_err", {31'h0, err0}, 32'h1);
    check("post_rst_rdata", rdata0, 32'h0);
    req0 = 1'b0;
    $display("reset with req held: first access started after rst_n rose");

    // Word store then signed/unsigned byte loads.
    acc0("st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hF0F0F0F0, rd, e);
    check("st_w20_rdata", rd, 32'h0);
    check("st_w20_err", {31'h0, e}, 32'h0);
    acc0("ld_b21s", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rd, e);
    check("ld_b21s_rdata", rd, 32'hFFFFFFF0);
    @(negedge clk);
    check("done_width", {31'h0, done0}, 32'h0);
    check("rdata_clear", rdata0, 32'h0);
    acc0("ld_b21u", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd, e);
    check("ld_b21u_rdata", rd, 32'h000000F0);

    // Halfword store merges into the upper half of an existing word.
    acc0("st_w28", 1'b1, 2'b10, 1'b0, 32'h28, 32'h00000005, rd, e);
    acc0("st_h2a", 1'b1, 2'b01, 1'b0, 32'h2A, 32'h1234ABCD, rd, e);
    acc0("ld_w28", 1'b0, 2'b10, 1'b0, 32'h28, 32'h0, rd, e);
    check("ld_w28_rdata", rd, 32'hABCD0005);
    acc0("ld_h2as", 1'b0, 2'b01, 1'b0, 32'h2A, 32'h0, rd, e);
    check("ld_h2as_rdata", rd, 32'hFFFFABCD);

    // Error cases: misaligned half, misaligned and out-of-range word store.
    acc0("ld_h23", 1'b0, 2'b01, 1'b0, 32'h23, 32'h0, rd, e);
    check("ld_h23_err", {31'h0, e}, 32'h1);
    check("ld_h23_rdata", rd, 32'h0);
    acc0("st_w31c", 1'b1, 2'b10, 1'b0, 32'h31C, 32'h11223344, rd, e);
    check("st_w31c_err", {31'h0, e}, 32'h0);
    acc0("st_w322", 1'b1, 2'b10, 1'b0, 32'h322, 32'hDEADBEEF, rd, e);
    check("st_w322_err", {31'h0, e}, 32'h1);
    acc0("ld_w31c", 1'b0, 2'b10, 1'b0, 32'h31C, 32'h0, rd, e);
    check("ld_w31c_rdata", rd, 32'h11223344);
    check("ld_w31c_err", {31'h0, e}, 32'h0);
    acc0("ld_w320", 1'b0, 2'b10, 1'b0, 32'h320, 32'h0, rd, e);
    check("ld_w320_err", {31'h0, e}, 32'h1);

    // Three wait states: latency 5, req pulse while busy ignored.
    @(negedge clk);
    req3 = 1'b1; we3 = 1'b1; size3 = 2'b10; addr3 = 32'h10; wdata3 = 32'hCAFEBABE;
    @(negedge clk);
    n = 1;
    req3 = 1'b0;
    check("ws3_busy", {31'h0, ready3}, 32'h0);
    @(negedge clk);
    n = 2;
    req3 = 1'b1; we3 = 1'b0; addr3 = 32'h44;
    @(negedge clk);
    n = 3;
    req3 = 1'b0;
    while (!done3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ws3_lat", 32'(n), 32'd5);
    check("ws3_err", {31'h0, err3}, 32'h0);
    $display("ws3 store addr=10 wdata=cafebabe lat=%0d", n);
    dcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done3) dcnt++;
    end
    check("ws3_pulse_ignored", 32'(dcnt), 32'd0);
    check("ws3_idle", {31'h0, ready3}, 32'h1);

    // Back-to-back loads with req held: done every 6 cycles.
    @(negedge clk);
    req3 = 1'b1; we3 = 1'b0; size3 = 2'b10; addr3 = 32'h10;
    t = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && t < 60) begin
      @(negedge clk);
      t++;
      if (done3) begin
        if (t1 < 0) begin
          t1 = t;
          check("ws3_ld_rdata", rdata3, 32'hCAFEBABE);
        end else begin
          t2 = t;
        end
      end
    end
    req3 = 1'b0;
    check("ws3_first_done", 32'(t1), 32'd5);
    check("ws3_spacing", 32'(t2 - t1), 32'd6);
    $display("ws3 back-to-back loads: done at %0d and %0d", t1, t2);
    repeat (12) @(negedge clk);

    // Reset during BUSY of a store: memory keeps the old word.
    acc0("st_w40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, rd, e);
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; size0 = 2'b10; addr0 = 32'h40; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    req0 = 1'b0;
    check("abort_busy", {31'h0, ready0}, 32'h0);
    #1 rst_n = 1'b0;
    #1 check("abort_ready", {31'h0, ready0}, 32'h1);
    @(negedge clk);
    check("abort_done", {31'h0, done0}, 32'h0);
    rst_n = 1'b1;
    $display("reset asserted during BUSY of store addr=40");
    acc0("ld_w40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, e);
    check("ld_w40_rdata", rd, 32'h12345678);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised successor to the single-cycle data memory, serving the datapath's MEM stage. It supports byte/halfword/word loads and stores with sign or zero extension and little-endian lane selection. Accesses use a req/ready/done handshake with a configurable number of wait states. Misaligned and out-of-range accesses are flagged instead of corrupting memory.

## Interface
- `DEPTH`, 200: number of 32-bit words; need not be a power of two.
- `ADDR_W`, 32: byte-address width.
- `WAIT_STATES`, 0: extra busy cycles per access, 0..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  1  access request; sampled only while `ready`=1.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as error).
- `uns`  in  1  load zero-extends when 1, sign-extends when 0.
- `addr`  in  ADDR_W  byte address.
- `wdata`  in  32  store data; low-order bits are used for byte/half.
- `ready`  out  1  high only in IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  load result; valid while `done`=1, 0 otherwise.
- `err`  out  1  valid with `done`: misaligned, out-of-range or reserved size.

## Operation
- FSM states: IDLE → BUSY → RESP → IDLE.
  - IDLE: `ready`=1. On `req`=1 at an edge, latch `we`, `size`, `uns`, `addr` and `wdata`. Load the wait counter with `WAIT_STATES` and go to BUSY.
  - BUSY: `ready`=0. Decrement the counter each edge. When the counter = 0, the edge performs the access and the FSM goes to RESP.
  - RESP: `done`=1, `rdata`/`err` driven from registers. Go to IDLE unconditionally.
- Address decode:
  - word index = `addr` >> 2.
  - lane = `addr`[1:0]; lane 0 = bits 7:0 (little-endian).
- Error conditions:
  - half access with `addr`[0]=1.
  - word access with `addr`[1:0]≠0.
  - word index ≥ `DEPTH`.
  - `size`=11.
- On error: no memory write, `rdata`=0, `err`=1.
- Store:
  - byte: write the selected lane only.
  - half: write lanes {addr[1],0} and {addr[1],1}.
  - word: write all four lanes.
  - Unselected lanes are preserved.
- Load:
  - Extract the selected lane(s).
  - Bit 7 (byte) or bit 15 (half) is replicated to bit 31 unless `uns`=1.
  - For stores, `rdata`=0.
- Memory array contents are not reset. The bench initialises them via hierarchical writes or a preceding store.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE, `ready`=1, `done`=0, `rdata`=0, `err`=0, wait counter=0.
- Reset mid-access drops the pending operation. No partial write occurs; memory retains its prior contents.
- Request accepted at the end of cycle 0:
  - cycles 1..`WAIT_STATES`+1: BUSY.
  - cycle `WAIT_STATES`+2: `done`=1.
  - cycle `WAIT_STATES`+3: `ready`=1.
- With `WAIT_STATES`=0, `done` occurs in cycle 2 and the next request can be accepted at the end of cycle 3.
- `req` is ignored while `ready`=0 and is not queued. The requester must hold or re-assert it.
- A store commits on the final BUSY edge. A load issued immediately after that store returns the new data.
- `done` is exactly one cycle wide. `rdata` and `err` return to 0 in the following cycle.

## Test plan
- Reset with `req`=1 held: `ready`=1, `done`=0 throughout reset; the first access starts only after `rst_n` rises.
- Store word 0xF0F0F0F0 @0x20, then load byte @0x21 (signed): `rdata`=0xFFFFFFF0. Same load with `uns`=1: `rdata`=0x000000F0.
- Store word 0x00000005 @0x28, then store half 0xABCD @0x2A, then load word @0x28: `rdata`=0xABCD0005.
- Load half @0x23: `done` with `err`=1, `rdata`=0. Store word @0x322 (misaligned, index 200 ≥ `DEPTH`): `err`=1, and a load of the neighbouring word 0x31C is unchanged.
- `WAIT_STATES`=3: `done` occurs 5 cycles after acceptance. `req` pulsed while BUSY is not serviced; back-to-back loads complete every 6 cycles.
- Assert `rst_n`=0 during BUSY of a store @0x40 (prior value 0x12345678): after reset, a load @0x40 returns 0x12345678.
